// File: rtl/cpu_memif_mq.sv
// CPU data-bus tracker: follows up to DEPTH outstanding transactions in request order,
// drives pending flags and an aligned, extended load result back to the memory stage.
module cpu_memif_mq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LSB_W  = $clog2(DATA_W / 8)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cpud_request,
    input  logic [LSB_W-1:0]           cpud_addr,
    input  logic [1:0]                 cpud_size,
    input  logic                       cpud_write,
    input  logic                       cpud_unsigned,
    input  logic [DATA_W-1:0]          cpud_rdata,
    input  logic                       cpud_ack,
    output logic                       p4_write_pending,
    output logic                       p4_read_pending,
    output logic [DATA_W-1:0]          p4_mem_rdata,
    output logic                       p4_rdata_valid,
    output logic                       p4_full,
    output logic [$clog2(DEPTH):0]     p4_count,
    output logic [1:0]                 p4_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Lane keep-masks; truncation to DATA_W makes a word keep everything on a 32-bit bus.
    localparam logic [DATA_W-1:0] KEEP_B = DATA_W'(64'h0000_0000_0000_00FF);
    localparam logic [DATA_W-1:0] KEEP_H = DATA_W'(64'h0000_0000_0000_FFFF);
    localparam logic [DATA_W-1:0] KEEP_W = DATA_W'(64'h0000_0000_FFFF_FFFF);

    function automatic logic [DATA_W-1:0] align_load(
        input logic [DATA_W-1:0] data,
        input logic [LSB_W-1:0]  addr,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [LSB_W-1:0]  lane;
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic              fill;
        case (size)
            2'b00:   lane = addr;
            2'b01:   lane = addr & ~LSB_W'(1'b1);
            2'b10:   lane = addr & ~LSB_W'(2'b11);
            default: lane = {LSB_W{1'b0}};
        endcase
        sh = data >> {lane, 3'b000};
        case (size)
            2'b00:   begin keep = KEEP_B; fill = !uns && sh[7];  end
            2'b01:   begin keep = KEEP_H; fill = !uns && sh[15]; end
            2'b10:   begin keep = KEEP_W; fill = !uns && sh[31]; end
            default: begin keep = {DATA_W{1'b1}}; fill = 1'b0;  end
        endcase
        return (sh & keep) | (fill ? ~keep : {DATA_W{1'b0}});
    endfunction

    logic              fifo_write_r [DEPTH];
    logic [1:0]        fifo_size_r  [DEPTH];
    logic [LSB_W-1:0]  fifo_addr_r  [DEPTH];
    logic              fifo_uns_r   [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic              full_r;
    logic [1:0]        err_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic              rdata_valid_r;

    logic              pop_s;
    logic              push_s;
    logic              head_write_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [CNT_W-1:0]  wr_cnt_next_s;
    logic [CNT_W-1:0]  rd_cnt_next_s;
    logic [1:0]        err_next_s;

    // Pop/push decisions; only entries registered in earlier cycles can be acknowledged.
    always_comb begin
        pop_s         = 1'b0;
        push_s        = 1'b0;
        head_write_s  = fifo_write_r[head_r];
        if (cpud_ack && (count_r != {CNT_W{1'b0}})) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (cpud_request && (!full_r || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        count_next_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        wr_cnt_next_s = wr_cnt_r + CNT_W'(push_s && cpud_write) - CNT_W'(pop_s && head_write_s);
        rd_cnt_next_s = rd_cnt_r + CNT_W'(push_s && !cpud_write) - CNT_W'(pop_s && !head_write_s);
        err_next_s    = err_r | {cpud_ack && (count_r == {CNT_W{1'b0}}),
                                 cpud_request && full_r && !pop_s};
    end

    // Pointers, occupancy counters, sticky error flags and the load-result register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            wr_cnt_r      <= {CNT_W{1'b0}};
            rd_cnt_r      <= {CNT_W{1'b0}};
            full_r        <= 1'b0;
            err_r         <= 2'b00;
            mem_rdata_r   <= {DATA_W{1'b0}};
            rdata_valid_r <= 1'b0;
        end else begin
            head_r   <= head_r + PTR_W'(pop_s);
            tail_r   <= tail_r + PTR_W'(push_s);
            count_r  <= count_next_s;
            wr_cnt_r <= wr_cnt_next_s;
            rd_cnt_r <= rd_cnt_next_s;
            full_r   <= (count_next_s == CNT_W'(DEPTH));
            err_r    <= err_next_s;
            if (pop_s && !head_write_s) begin
                mem_rdata_r   <= align_load(cpud_rdata, fifo_addr_r[head_r],
                                            fifo_size_r[head_r], fifo_uns_r[head_r]);
                rdata_valid_r <= 1'b1;
            end else begin
                rdata_valid_r <= 1'b0;
            end
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_write_r[i] <= 1'b0;
                fifo_size_r[i]  <= 2'b00;
                fifo_addr_r[i]  <= {LSB_W{1'b0}};
                fifo_uns_r[i]   <= 1'b0;
            end
        end else if (push_s) begin
            fifo_write_r[tail_r] <= cpud_write;
            fifo_size_r[tail_r]  <= cpud_size;
            fifo_addr_r[tail_r]  <= cpud_addr;
            fifo_uns_r[tail_r]   <= cpud_unsigned;
        end
    end

    // Pending flags look through the ack so the CPU can resume in the ack cycle itself.
    assign p4_write_pending = (wr_cnt_r - CNT_W'(pop_s && head_write_s)) != {CNT_W{1'b0}};
    assign p4_read_pending  = (rd_cnt_r - CNT_W'(pop_s && !head_write_s)) != {CNT_W{1'b0}};
    assign p4_mem_rdata     = mem_rdata_r;
    assign p4_rdata_valid   = rdata_valid_r;
    assign p4_full          = full_r;
    assign p4_count         = count_r;
    assign p4_err           = err_r;

endmodule

// File: tb/tb_cpu_memif_mq.sv
// Bench for cpu_memif_mq: a 32-bit and a 64-bit instance share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_cpu_memif_mq;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req, wr, uns, ack;
    logic [2:0]  addr;
    logic [1:0]  size;
    logic [63:0] rdata;

    logic        wp32, rp32, v32, f32;
    logic [31:0] md32;
    logic [2:0]  cnt32;
    logic [1:0]  err32;
    logic        wp64, rp64, v64, f64;
    logic [63:0] md64;
    logic [2:0]  cnt64;
    logic [1:0]  err64;

    always #5 clock = ~clock;

    cpu_memif_mq #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
        .clock(clock), .reset_n(reset_n), .cpud_request(req), .cpud_addr(addr[1:0]),
        .cpud_size(size), .cpud_write(wr), .cpud_unsigned(uns), .cpud_rdata(rdata[31:0]),
        .cpud_ack(ack), .p4_write_pending(wp32), .p4_read_pending(rp32), .p4_mem_rdata(md32),
        .p4_rdata_valid(v32), .p4_full(f32), .p4_count(cnt32), .p4_err(err32));

    cpu_memif_mq #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
        .clock(clock), .reset_n(reset_n), .cpud_request(req), .cpud_addr(addr),
        .cpud_size(size), .cpud_write(wr), .cpud_unsigned(uns), .cpud_rdata(rdata),
        .cpud_ack(ack), .p4_write_pending(wp64), .p4_read_pending(rp64), .p4_mem_rdata(md64),
        .p4_rdata_valid(v64), .p4_full(f64), .p4_count(cnt64), .p4_err(err64));

    typedef struct packed {
        logic       w;
        logic [1:0] size;
        logic [2:0] addr;
        logic       uns;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    ent_t        mq[$];
    logic        m_err0, m_err1, m_valid;
    logic [63:0] m_rd32, m_rd64;

    // Load result from first principles: access bytes, naturally aligned offset, extension.
    function automatic logic [63:0] ref_load(input logic [63:0] data, input ent_t e, input int w);
        int          wb;
        int          nb;
        int          off;
        logic [63:0] m;
        logic [63:0] v;
        wb  = w / 8;
        nb  = 1 << e.size;
        if (nb > wb) nb = wb;
        off = ((int'(e.addr) % wb) / nb) * nb;
        m   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v   = (data >> (8 * off)) & m;
        if (!e.uns && v[8 * nb - 1]) v = v | ~m;
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_err0 = 1'b0; m_err1 = 1'b0; m_valid = 1'b0;
        m_rd32 = 64'd0; m_rd64 = 64'd0;
    endtask

    task automatic cycle(input logic r, input logic w_, input logic [1:0] sz, input logic [2:0] a,
                         input logic u, input logic k, input logic [63:0] d);
        int   nw;
        int   nr;
        bit   pop;
        ent_t e;
        req = r; wr = w_; size = sz; addr = a; uns = u; ack = k; rdata = d;
        #2;
        pop = k && (mq.size() > 0);
        nw = 0; nr = 0;
        foreach (mq[i]) begin
            if (mq[i].w) nw++; else nr++;
        end
        if (pop) begin
            if (mq[0].w) nw--; else nr--;
        end
        chk("write_pending32", wp32, nw != 0);
        chk("read_pending32",  rp32, nr != 0);
        chk("write_pending64", wp64, nw != 0);
        chk("read_pending64",  rp64, nr != 0);
        m_valid = 1'b0;
        if (pop) begin
            e = mq.pop_front();
            if (!e.w) begin
                m_valid = 1'b1;
                m_rd32  = ref_load(d, e, 32);
                m_rd64  = ref_load(d, e, 64);
            end
        end else if (k) begin
            m_err1 = 1'b1;
        end
        if (r) begin
            if (mq.size() < DEPTH) mq.push_back('{w_, sz, a, u});
            else m_err0 = 1'b1;
        end
        @(posedge clock);
        #1;
        req = 1'b0; ack = 1'b0;
        chk("count32", cnt32, mq.size());
        chk("count64", cnt64, mq.size());
        chk("full32",  f32, mq.size() == DEPTH);
        chk("full64",  f64, mq.size() == DEPTH);
        chk("err32",   err32, {m_err1, m_err0});
        chk("err64",   err64, {m_err1, m_err0});
        chk("valid32", v32, m_valid);
        chk("valid64", v64, m_valid);
        chk("rdata32", md32, m_rd32);
        chk("rdata64", md64, m_rd64);
    endtask

    task automatic async_reset();
        req = 1'b0; ack = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_wp",  {wp32, wp64}, 2'b00);
        chk("rst_rp",  {rp32, rp64}, 2'b00);
        chk("rst_v",   {v32, v64}, 2'b00);
        chk("rst_f",   {f32, f64}, 2'b00);
        chk("rst_cnt", {cnt32, cnt64}, 6'd0);
        chk("rst_err", {err32, err64}, 4'd0);
        chk("rst_md32", md32, 64'd0);
        chk("rst_md64", md64, 64'd0);
        model_clear();
        @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 64'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        req = 1'b0; wr = 1'b0; uns = 1'b0; ack = 1'b0;
        addr = 3'd0; size = 2'b00; rdata = 64'd0;
        #2;
        async_reset();
        idle();

        // Signed byte read at lane 3.
        cycle(1'b1, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0, 64'd0);
        chk("t1_rp_after_req", rp32, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_80FF_FFFF);
        chk("t1_rdata", md32, 64'h0000_0000_FFFF_FF80);
        chk("t1_valid", v32, 1'b1);

        // Unsigned half read at lane 2.
        cycle(1'b1, 1'b0, 2'b01, 3'd2, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_8001_1234);
        chk("t2_rdata", md32, 64'h0000_0000_0000_8001);

        // Fill the queue, overflow it, then drain with mixed acks.
        cycle(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 2'b10, 3'd0, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 64'd0);
        chk("t3_count", cnt32, 3'd4);
        chk("t3_full",  f32, 1'b1);
        chk("t3_pend",  {wp32, rp32}, 2'b11);
        cycle(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 64'd0);
        chk("t3_err_overflow", err32, 2'b01);
        chk("t3_count_held",   cnt32, 3'd4);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_0000_000A);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_0000_000B);
        chk("t3_rdata_b", md32, 64'h0000_0000_0000_000B);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_0000_000C);
        chk("t3_wp_after_3rd", wp32, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_0000_00D7);
        chk("t3_rdata_d7", md32, 64'h0000_0000_FFFF_FFD7);

        // Doubleword and upper-lane word reads.
        cycle(1'b1, 1'b0, 2'b11, 3'd0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h8000_0000_0000_0001);
        chk("t4_dword64", md64, 64'h8000_0000_0000_0001);
        chk("t4_dword_as_word32", md32, 64'h0000_0000_0000_0001);
        cycle(1'b1, 1'b0, 2'b10, 3'd4, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h89AB_CDEF_0123_4567);
        chk("t4_word_hi64", md64, 64'hFFFF_FFFF_89AB_CDEF);
        chk("t4_word_lo32", md32, 64'h0000_0000_0123_4567);

        // Reset arriving with a write still in flight and a fresh load result.
        cycle(1'b1, 1'b0, 2'b00, 3'd1, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h0000_0000_0000_FF00);
        #2;
        async_reset();

        // Spurious acks: after reset, and alongside the request filling an empty queue.
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'd0);
        chk("t5_err_spurious", err32, 2'b10);
        chk("t5_count0", cnt32, 3'd0);
        cycle(1'b1, 1'b0, 2'b10, 3'd0, 1'b0, 1'b1, 64'd0);
        chk("t5_count1", cnt32, 3'd1);
        cycle(1'b1, 1'b1, 2'b00, 3'd1, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 2'b01, 3'd2, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 2'b00, 3'd3, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 64'h1122_3344_5566_7788);
        chk("t6_full_push_pop_count", cnt32, 3'd4);
        chk("t6_full_push_pop_err",   err32, 2'b10);
        repeat (4) cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, {$urandom, $urandom});

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 99) < 50, 1'($urandom), 2'($urandom), 3'($urandom),
                  1'($urandom), $urandom_range(0, 99) < 45, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
